psram_qspi_model: RTL and testbench

//  Parametrised, synthesizable QSPI/QPI PSRAM slave model for SoC simulation and FPGA bring-up.

---
 rtl/psram_qspi_model_if.sv | 19 +
 rtl/psram_qspi_model.sv | 231 +++++++++++++++++++++++
 tb/tb_psram_qspi_model.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_qspi_model_if.sv
// psram_qspi_model_if: PSRAM pad-side pins between controller and slave.
// Split tri-state: dio_o/dio_oe from slave, dio_i sampled from the pad.
interface psram_qspi_model_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] dio_i;
  logic [3:0] dio_o;
  logic [3:0] dio_oe;

  modport master (
    output sck, ce_n, dio_i,
    input  dio_o, dio_oe
  );

  modport slave (
    input  sck, ce_n, dio_i,
    output dio_o, dio_oe
  );
endinterface

// File: rtl/psram_qspi_model.sv
// psram_qspi_model: QSPI/QPI PSRAM slave oversampled in the system clock
// domain; SPI/QPI entry/exit, 24-bit address, dummy cycles, wrapping bursts.
module psram_qspi_model #(
  parameter int MEM_DEPTH    = 4096,
  parameter int DUMMY_CYCLES = 6,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clock,
  input  logic              rst_n,
  psram_qspi_model_if.slave pins,
  output logic              qpi_mode,
  output logic              busy,
  output logic              cmd_err
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0]      sck_sync, ce_sync;
  logic [SYNC_STAGES-1:0][3:0] dio_sync;
  logic                        sck_q, ce_q;
  logic                        sck_s, ce_s;
  logic [3:0]                  dio_s;
  logic                        sck_rise, sck_fall, ce_rise;

  logic [3:0]    cnt, cnt_n;
  logic [23:0]   shreg, shreg_n;
  logic [23:0]   sh_nib, sh_bit;
  logic          is_wr, is_wr_n;
  logic [AW-1:0] addr, addr_n;
  logic          half, half_n;
  logic [3:0]    wnib, wnib_n;
  logic          pend, pend_n;
  logic          pend_vld, pend_vld_n;
  logic [3:0]    dout, dout_n;
  logic          doe, doe_n;
  logic          qpi_n, busy_n, err_n;
  logic          mem_we;
  logic [7:0]    mem_wd, rd_byte;

  logic [7:0] mem [MEM_DEPTH];

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ce_s     = ce_sync[SYNC_STAGES-1];
  assign dio_s    = dio_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign ce_rise  = ce_s & ~ce_q;

  assign pins.dio_o  = dout;
  assign pins.dio_oe = {4{doe}};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync <= '0;
      ce_sync  <= '1;
      dio_sync <= '0;
      sck_q    <= 1'b0;
      ce_q     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], pins.sck};
      ce_sync  <= {ce_sync[SYNC_STAGES-2:0], pins.ce_n};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], pins.dio_i};
      sck_q    <= sck_s;
      ce_q     <= ce_s;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      is_wr    <= 1'b0;
      addr     <= '0;
      half     <= 1'b0;
      wnib     <= '0;
      pend     <= 1'b0;
      pend_vld <= 1'b0;
      dout     <= '0;
      doe      <= 1'b0;
      qpi_mode <= 1'b0;
      busy     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      is_wr    <= is_wr_n;
      addr     <= addr_n;
      half     <= half_n;
      wnib     <= wnib_n;
      pend     <= pend_n;
      pend_vld <= pend_vld_n;
      dout     <= dout_n;
      doe      <= doe_n;
      qpi_mode <= qpi_n;
      busy     <= busy_n;
      cmd_err  <= err_n;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[addr] <= mem_wd;
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    is_wr_n    = is_wr;
    addr_n     = addr;
    half_n     = half;
    wnib_n     = wnib;
    pend_n     = pend;
    pend_vld_n = pend_vld;
    dout_n     = dout;
    doe_n      = doe;
    qpi_n      = qpi_mode;
    busy_n     = busy;
    err_n      = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = {wnib, dio_s};
    rd_byte    = mem[addr];
    sh_nib     = {shreg[19:0], dio_s};
    sh_bit     = {shreg[22:0], dio_s[0]};

    // Frame end outranks any sck edge seen in the same clock
    if (ce_rise) begin
      state_n    = IDLE;
      cnt_n      = '0;
      half_n     = 1'b0;
      doe_n      = 1'b0;
      busy_n     = 1'b0;
      pend_vld_n = 1'b0;
      if (pend_vld) qpi_n = pend;
    end else begin
      unique case (state)
        IDLE: begin
          if (!ce_s) begin
            state_n    = CMD;
            busy_n     = 1'b1;
            cnt_n      = '0;
            half_n     = 1'b0;
            pend_vld_n = 1'b0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            shreg_n = qpi_mode ? sh_nib : sh_bit;
            cnt_n   = cnt + 4'd1;
            if (cnt == (qpi_mode ? 4'd1 : 4'd7)) begin
              cnt_n = '0;
              unique case (shreg_n[7:0])
                8'hEB: begin
                  state_n = ADDR;
                  is_wr_n = 1'b0;
                end
                8'h38: begin
                  state_n = ADDR;
                  is_wr_n = 1'b1;
                end
                8'h35: begin
                  state_n    = IGNORE;
                  pend_n     = 1'b1;
                  pend_vld_n = 1'b1;
                end
                8'hF5: begin
                  state_n    = IGNORE;
                  pend_n     = 1'b0;
                  pend_vld_n = 1'b1;
                end
                default: begin
                  state_n = IGNORE;
                  err_n   = 1'b1;
                end
              endcase
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            shreg_n = sh_nib;
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd5) begin
              cnt_n  = '0;
              half_n = 1'b0;
              addr_n = sh_nib[AW-1:0];
              if (is_wr) state_n = WDATA;
              else state_n = (DUMMY_CYCLES == 0) ? RDATA : DUMMY;
            end
          end
        end
        DUMMY: begin
          if (sck_rise) begin
            cnt_n = cnt + 4'd1;
            if (cnt == 4'(DUMMY_CYCLES - 1)) begin
              cnt_n   = '0;
              state_n = RDATA;
            end
          end
        end
        RDATA: begin
          if (sck_fall) begin
            doe_n  = 1'b1;
            half_n = ~half;
            dout_n = half ? rd_byte[3:0] : rd_byte[7:4];
            if (half) addr_n = addr + AW'(1);
          end
        end
        WDATA: begin
          if (sck_rise) begin
            half_n = ~half;
            if (!half) begin
              wnib_n = dio_s;
            end else begin
              mem_we = 1'b1;
              addr_n = addr + AW'(1);
            end
          end
        end
        IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psram_qspi_model.sv
// tb_psram_qspi_model: randomized self-checking bench against a byte-array
// model of the PSRAM plus a mode flag, driving pins as a slow controller.
module tb_psram_qspi_model;
  localparam int DEPTH = 4096;
  localparam int DUMMY = 6;
  localparam int SYNC  = 2;
  localparam int HALF  = 5;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic qpi_mode, busy, cmd_err;

  psram_qspi_model_if bus();

  psram_qspi_model #(
    .MEM_DEPTH(DEPTH),
    .DUMMY_CYCLES(DUMMY),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .pins(bus),
    .qpi_mode(qpi_mode),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  int err_pulses = 0;
  int oe_clks = 0;

  logic [7:0] ref_mem [DEPTH];
  bit         ref_val [DEPTH];
  bit         ref_qpi = 1'b0;

  always @(negedge clock) begin
    if (cmd_err === 1'b1) err_pulses <= err_pulses + 1;
    if (bus.dio_oe !== 4'h0) oe_clks <= oe_clks + 1;
  end

  task automatic half_wait();
    repeat (HALF) @(negedge clock);
  endtask

  task automatic nib(input logic [3:0] d, output logic [3:0] q,
                     output logic [3:0] oe);
    bus.dio_i = d;
    half_wait();
    q = bus.dio_o;
    oe = bus.dio_oe;
    bus.sck = 1'b1;
    half_wait();
    bus.sck = 1'b0;
  endtask

  task automatic start_frame();
    bus.ce_n = 1'b0;
    half_wait();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL busy_in_frame: got %b expected 1", busy);
    else n_pass++;
  endtask

  task automatic end_frame();
    half_wait();
    bus.ce_n = 1'b1;
    repeat (2 * HALF) @(negedge clock);
  endtask

  task automatic send_cmd(input logic [7:0] op);
    logic [3:0] q, oe, r;
    if (ref_qpi) begin
      nib(op[7:4], q, oe);
      nib(op[3:0], q, oe);
    end else begin
      for (int i = 7; i >= 0; i--) begin
        r = 4'($urandom);
        r[0] = op[i];
        nib(r, q, oe);
      end
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] q, oe;
    for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4], q, oe);
  endtask

  task automatic wr_frame(input logic [23:0] a, input logic [7:0] data[$]);
    logic [3:0] q, oe;
    int idx;
    start_frame();
    send_cmd(8'h38);
    send_addr(a);
    foreach (data[i]) begin
      nib(data[i][7:4], q, oe);
      nib(data[i][3:0], q, oe);
      idx = (int'(a) + i) % DEPTH;
      ref_mem[idx] = data[i];
      ref_val[idx] = 1'b1;
    end
    end_frame();
  endtask

  task automatic mode_frame(input logic [7:0] op);
    start_frame();
    send_cmd(op);
    end_frame();
    ref_qpi = (op == 8'h35);
    n_chk++;
    if (qpi_mode !== ref_qpi)
      $display("FAIL mode_%h: got %b expected %b", op, qpi_mode, ref_qpi);
    else n_pass++;
  endtask

  task automatic rd_body(input logic [23:0] a, input int n);
    logic [3:0] q1, q2, o1, o2;
    bit oe_seen;
    int idx;
    oe_seen = 1'b0;
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < DUMMY; i++) begin
      nib(4'($urandom), q1, o1);
      if (o1 !== 4'h0) oe_seen = 1'b1;
    end
    n_chk++;
    if (oe_seen) $display("FAIL dummy_oe: got oe active expected 0");
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      nib(4'($urandom), q1, o1);
      nib(4'($urandom), q2, o2);
      idx = (int'(a) + i) % DEPTH;
      if (ref_val[idx]) begin
        n_chk++;
        if ({q1, q2} !== ref_mem[idx] || o1 !== 4'hF || o2 !== 4'hF)
          $display("FAIL rd_byte[%0d]: got %h oe %h/%h expected %h oe F/F",
                   idx, {q1, q2}, o1, o2, ref_mem[idx]);
        else n_pass++;
      end
    end
  endtask

  task automatic rd_frame(input logic [23:0] a, input int n);
    start_frame();
    rd_body(a, n);
    end_frame();
  endtask

  task automatic test_reset();
    bus.sck = 1'b0;
    bus.ce_n = 1'b1;
    bus.dio_i = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    n_chk += 5;
    if (bus.dio_o !== 4'h0) $display("FAIL rst_dio_o: got %h expected 0", bus.dio_o);
    else n_pass++;
    if (bus.dio_oe !== 4'h0) $display("FAIL rst_dio_oe: got %h expected 0", bus.dio_oe);
    else n_pass++;
    if (qpi_mode !== 1'b0) $display("FAIL rst_qpi: got %b expected 0", qpi_mode);
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy);
    else n_pass++;
    if (cmd_err !== 1'b0) $display("FAIL rst_cmd_err: got %b expected 0", cmd_err);
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_spi_basic();
    wr_frame(24'h000010, '{8'hA5, 8'h3C});
    rd_frame(24'h000010, 2);
  endtask

  task automatic test_qpi_mode();
    start_frame();
    send_cmd(8'h35);
    n_chk++;
    if (qpi_mode !== 1'b0) $display("FAIL qpi_early: got %b expected 0", qpi_mode);
    else n_pass++;
    end_frame();
    ref_qpi = 1'b1;
    n_chk++;
    if (qpi_mode !== 1'b1) $display("FAIL qpi_enter: got %b expected 1", qpi_mode);
    else n_pass++;
    rd_frame(24'h000010, 2);
    mode_frame(8'hF5);
  endtask

  task automatic test_abort_cmd();
    logic [3:0] q, oe;
    int e0;
    e0 = err_pulses;
    start_frame();
    for (int i = 7; i >= 4; i--) nib({3'b000, 8'h35 >> i & 1}, q, oe);
    end_frame();
    n_chk++;
    if (qpi_mode !== 1'b0 || err_pulses != e0)
      $display("FAIL abort_cmd: got qpi %b err %0d expected qpi 0 err 0",
               qpi_mode, err_pulses - e0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    wr_frame(24'(DEPTH - 1), '{8'h11, 8'h22});
    rd_frame(24'(DEPTH - 1), 2);
    rd_frame(24'h000000, 1);
  endtask

  task automatic test_bad_opcode();
    logic [3:0] q, oe;
    int e0, o0;
    e0 = err_pulses;
    o0 = oe_clks;
    start_frame();
    send_cmd(8'h9F);
    for (int i = 0; i < 8; i++) nib(4'($urandom), q, oe);
    end_frame();
    n_chk += 2;
    if (err_pulses - e0 != 1)
      $display("FAIL bad_op_err: got %0d pulses expected 1", err_pulses - e0);
    else n_pass++;
    if (oe_clks != o0)
      $display("FAIL bad_op_oe: got %0d oe clocks expected 0", oe_clks - o0);
    else n_pass++;
    rd_frame(24'h000010, 2);
  endtask

  task automatic test_partial_write();
    logic [3:0] q, oe;
    logic [23:0] a;
    int k;
    a = 24'($urandom_range(0, DEPTH - 2));
    wr_frame(a + 24'd1, '{8'($urandom)});
    start_frame();
    send_cmd(8'h38);
    send_addr(a);
    nib(4'h7, q, oe);
    nib(4'h8, q, oe);
    nib(4'h9, q, oe);
    end_frame();
    ref_mem[a] = 8'h78;
    ref_val[a] = 1'b1;
    rd_frame(a, 2);
    start_frame();
    rd_body(a, 1);
    bus.ce_n = 1'b1;
    k = 0;
    while (bus.dio_oe !== 4'h0 && k < 10) begin
      @(negedge clock);
      k++;
    end
    n_chk++;
    if (k > SYNC + 2)
      $display("FAIL oe_release: got %0d clocks expected <= %0d", k, SYNC + 2);
    else n_pass++;
    repeat (2 * HALF) @(negedge clock);
  endtask

  task automatic test_random();
    logic [7:0] data[$];
    logic [23:0] a;
    int n;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) mode_frame(ref_qpi ? 8'hF5 : 8'h35);
      n = $urandom_range(1, 4);
      a = 24'($urandom);
      if ($urandom_range(0, 3) == 0)
        a[11:0] = 12'(DEPTH - $urandom_range(1, 3));
      data = {};
      for (int i = 0; i < n; i++) data.push_back(8'($urandom));
      wr_frame(a, data);
      rd_frame(a ^ 24'($urandom_range(0, 15) << 12), n);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] a;
    if (!ref_qpi) mode_frame(8'h35);
    a = 24'($urandom);
    wr_frame(a, '{8'($urandom), 8'($urandom)});
    start_frame();
    rd_body(a, 1);
    rst_n = 1'b0;
    #1;
    n_chk += 3;
    if (bus.dio_oe !== 4'h0) $display("FAIL mid_rst_oe: got %h expected 0", bus.dio_oe);
    else n_pass++;
    if (qpi_mode !== 1'b0) $display("FAIL mid_rst_qpi: got %b expected 0", qpi_mode);
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy);
    else n_pass++;
    bus.ce_n = 1'b1;
    bus.sck = 1'b0;
    repeat (4) @(negedge clock);
    rst_n = 1'b1;
    repeat (4) @(negedge clock);
    ref_qpi = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_val[i] = 1'b0;
    a = 24'($urandom);
    wr_frame(a, '{8'($urandom), 8'($urandom), 8'($urandom)});
    rd_frame(a, 3);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_val[i] = 1'b0;
    test_reset();
    test_spi_basic();
    test_qpi_mode();
    test_abort_cmd();
    test_wrap();
    test_bad_opcode();
    test_partial_write();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
